// File: rtl/row_array_scanner.sv
// Double-buffered 8x8 LED row scanner. Game writes land in a back buffer, which is
// promoted to the display buffer only at frame wrap so a scan never shows a half-updated image.
module row_array_scanner #(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [15:0] BLANK_CYC = 16'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clrarray,
    input  logic       writeStrobe,
    input  logic [2:0] rowIndex,
    input  logic [7:0] val,
    output logic [7:0] row_n,
    output logic [7:0] col,
    output logic [2:0] scan_row,
    output logic       frame_tick
);

    logic [15:0] div_q;
    logic [2:0]  scanRow_q;
    logic [7:0]  back_q [8];
    logic [7:0]  disp_q [8];
    logic        dirty_q;
    logic [7:0]  rowN_q;
    logic [7:0]  col_q;
    logic        frameTick_q;

    logic lastDiv;
    logic frameWrap;
    logic blanking;

    assign lastDiv   = (div_q == SCAN_DIV - 16'd1);
    assign frameWrap = lastDiv && (scanRow_q == 3'd7);
    // Widened compare keeps BLANK_CYC == 0 meaningful (never blank) without an always-false test.
    assign blanking  = (({1'b0, div_q} + 17'd1) <= {1'b0, BLANK_CYC});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            scanRow_q <= '0;
        end else begin
            if (lastDiv) begin
                div_q     <= '0;
                scanRow_q <= scanRow_q + 3'd1;
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

    // A write in the wrap cycle lands in back but is not part of this snapshot; dirty stays set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                back_q[i] <= '0;
                disp_q[i] <= '0;
            end
            dirty_q <= 1'b0;
        end else if (clrarray) begin
            for (int i = 0; i < 8; i++) begin
                back_q[i] <= '0;
                disp_q[i] <= '0;
            end
            dirty_q <= 1'b0;
        end else begin
            if (frameWrap && dirty_q) begin
                for (int i = 0; i < 8; i++) begin
                    disp_q[i] <= back_q[i];
                end
                dirty_q <= 1'b0;
            end
            if (writeStrobe) begin
                back_q[rowIndex] <= val;
                dirty_q          <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rowN_q      <= 8'hFF;
            col_q       <= 8'h00;
            frameTick_q <= 1'b0;
        end else begin
            frameTick_q <= frameWrap;
            if (blanking) begin
                rowN_q <= 8'hFF;
                col_q  <= 8'h00;
            end else begin
                rowN_q <= ~(8'h01 << scanRow_q);
                col_q  <= disp_q[scanRow_q];
            end
        end
    end

    assign row_n      = rowN_q;
    assign col        = col_q;
    assign scan_row   = scanRow_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_row_array_scanner.sv
// Scoreboard bench for row_array_scanner: stimulus queues the expected contents of each lit row
// slot, and a monitor pops one entry whenever a row slot lights up.
module tb_row_array_scanner;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, clrarray, writeStrobe;
    logic [2:0] rowIndex;
    logic [7:0] val;
    logic [7:0] row_n, col;
    logic [2:0] scan_row;
    logic       frame_tick;

    logic       resetB, clrB, wsB;
    logic [2:0] riB;
    logic [7:0] valB;
    logic [7:0] rowNB, colB;
    logic [2:0] scanRowB;
    logic       tickB;

    row_array_scanner #(.SCAN_DIV(16'd4), .BLANK_CYC(16'd1)) dut (
        .clk(clk), .reset(reset), .clrarray(clrarray), .writeStrobe(writeStrobe),
        .rowIndex(rowIndex), .val(val), .row_n(row_n), .col(col),
        .scan_row(scan_row), .frame_tick(frame_tick)
    );

    row_array_scanner #(.SCAN_DIV(16'd2), .BLANK_CYC(16'd0)) dutB (
        .clk(clk), .reset(resetB), .clrarray(clrB), .writeStrobe(wsB),
        .rowIndex(riB), .val(valB), .row_n(rowNB), .col(colB),
        .scan_row(scanRowB), .frame_tick(tickB)
    );

    typedef struct packed {
        logic [7:0] rowN;
        logic [7:0] col;
    } slot_t;

    slot_t      expQ[$];
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] rowPat [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] img [8];
    int         nCyc;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic clr, input logic ws, input logic [2:0] r, input logic [7:0] v);
        clrarray    = clr;
        writeStrobe = ws;
        rowIndex    = r;
        val         = v;
        @(negedge clk);
        clrarray    = 1'b0;
        writeStrobe = 1'b0;
    endtask

    task automatic pushFrame(input logic [7:0] rows [8], input int nRows);
        for (int r = 0; r < nRows; r++) expQ.push_back('{rowN: rowPat[r], col: rows[r]});
    endtask

    task automatic waitTick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        if (!frame_tick) checkOutput("tickTimeout", 32'd0, 32'd1);
    endtask

    // Monitor: one scoreboard pop per lit slot, then the slot must hold steady until it blanks.
    logic  monPrevLit = 1'b0;
    logic  monHeldValid = 1'b0;
    logic  lit;
    slot_t monHeld;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                monPrevLit   = 1'b0;
                monHeldValid = 1'b0;
            end else begin
                lit = (row_n !== 8'hFF);
                checkOutput("oneHot", ($countones(~row_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
                if (!lit) begin
                    checkOutput("blankCol", col, 8'h00);
                    monHeldValid = 1'b0;
                end else if (!monPrevLit) begin
                    if (expQ.size() > 0) begin
                        monHeld      = expQ.pop_front();
                        monHeldValid = 1'b1;
                        checkOutput("slotRowN", row_n, monHeld.rowN);
                        checkOutput("slotCol", col, monHeld.col);
                    end else begin
                        monHeldValid = 1'b0;
                    end
                end else if (monHeldValid) begin
                    checkOutput("holdRowN", row_n, monHeld.rowN);
                    checkOutput("holdCol", col, monHeld.col);
                end
                monPrevLit = lit;
            end
        end
    end

    initial begin
        reset = 1'b1; clrarray = 1'b0; writeStrobe = 1'b0; rowIndex = '0; val = '0;
        resetB = 1'b1; clrB = 1'b0; wsB = 1'b0; riB = '0; valB = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstRowN", row_n, 8'hFF);
        checkOutput("rstCol", col, 8'h00);
        checkOutput("rstScanRow", scan_row, 3'd0);
        checkOutput("rstTick", frame_tick, 1'b0);

        // Blank display after reset, 32-cycle frame period.
        reset = 1'b0;
        img = '{default: 8'h00};
        pushFrame(img, 8);
        waitTick(nCyc);
        checkOutput("framePeriod", nCyc, 32'd32);
        checkOutput("tickScanRow", scan_row, 3'd0);

        // Mid-frame write is held back until the next wrap.
        pushFrame(img, 8);
        @(negedge clk);
        checkOutput("tickPulse", frame_tick, 1'b0);
        repeat (8) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd2, 8'hE0);
        waitTick(nCyc);
        img[2] = 8'hE0;
        pushFrame(img, 8);
        waitTick(nCyc);

        // Write in the wrap cycle skips one frame.
        pushFrame(img, 8);
        repeat (31) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 8'h3C);
        checkOutput("tickAtWrap", frame_tick, 1'b1);
        pushFrame(img, 8);
        waitTick(nCyc);
        img[0] = 8'h3C;
        pushFrame(img, 8);

        // Load a diagonal, then clear coincident with a row-5 write.
        @(negedge clk);
        for (int r = 0; r < 8; r++) applyStimulus(1'b0, 1'b1, 3'(r), 8'h01 << r);
        waitTick(nCyc);
        for (int r = 0; r < 8; r++) img[r] = 8'h01 << r;
        pushFrame(img, 2);
        repeat (10) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 3'd5, 8'hFF);
        checkOutput("clrLagCol", col, 8'h04);
        @(negedge clk);
        checkOutput("clrDarkCol", col, 8'h00);
        checkOutput("clrDarkRowN", row_n, 8'hFB);
        applyStimulus(1'b0, 1'b1, 3'd4, 8'hAA);
        waitTick(nCyc);

        // Async reset in row 4, div 2.
        img = '{default: 8'h00};
        img[4] = 8'hAA;
        pushFrame(img, 5);
        repeat (18) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRowN", row_n, 8'hFF);
        checkOutput("asyncCol", col, 8'h00);
        checkOutput("asyncScanRow", scan_row, 3'd0);
        checkOutput("asyncTick", frame_tick, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        img = '{default: 8'h00};
        pushFrame(img, 8);
        waitTick(nCyc);
        checkOutput("restartPeriod", nCyc, 32'd32);
        checkOutput("queueDrained", expQ.size(), 32'd0);

        // No-blank configuration: a row is always driven.
        @(negedge clk);
        #2 resetB = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checkOutput("noBlankRowN", rowNB, rowPat[((k - 1) / 2) % 8]);
            checkOutput("noBlankCol", colB, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
